// File: rtl/wl_pkg.sv
// Shared width helpers and the tile type macro for the multi-bank weight-load stage.
`ifndef WL_TILE_T
`define WL_TILE_T(MW, DW) logic [(MW)-1:0][(MW)-1:0][(DW)-1:0]
`endif

package wl_pkg;

    // Bank pointer / beat index width; never zero so 1-bit indices stay legal.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width: must hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wl_tile_bank.sv
// One MESH_WIDTH x MESH_WIDTH tile bank; a beat scatters into a row or,
// when transposed, into a column.
module wl_tile_bank
    import wl_pkg::*;
#(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clr_i,
    input  logic                             we_i,
    input  logic [IDX_W-1:0]                 idx_i,
    input  logic                             transpose_i,
    input  logic [MESH_WIDTH*DATA_WIDTH-1:0] data_i,
    output `WL_TILE_T(MESH_WIDTH, DATA_WIDTH) tile_o
);

    `WL_TILE_T(MESH_WIDTH, DATA_WIDTH) tile_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tile_q <= '0;
        end else if (clr_i) begin
            tile_q <= '0;
        end else if (we_i) begin
            for (int j = 0; j < MESH_WIDTH; j++) begin
                if (transpose_i) begin
                    tile_q[j][idx_i] <= data_i[DATA_WIDTH*j +: DATA_WIDTH];
                end else begin
                    tile_q[idx_i][j] <= data_i[DATA_WIDTH*j +: DATA_WIDTH];
                end
            end
        end
    end

    assign tile_o = tile_q;

endmodule

// File: rtl/wl_stage_mb.sv
// Multi-bank weight-load stage: assembles row beats into a ring of tile banks and
// presents the oldest complete tile to the mesh until it is released.
module wl_stage_mb
    import wl_pkg::*;
#(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BUFS   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             w_valid_i,
    output logic                             w_ready_o,
    input  logic [MESH_WIDTH*DATA_WIDTH-1:0] w_data_i,
    input  logic                             w_transpose_i,
    output logic                             mesh_valid_o,
    input  logic                             mesh_release_i,
    output `WL_TILE_T(MESH_WIDTH, DATA_WIDTH) weight_o,
    output logic [cnt_w(NUM_BUFS)-1:0]       full_cnt_o
);

    localparam int unsigned PTR_W = ptr_w(NUM_BUFS);
    localparam int unsigned CNT_W = cnt_w(NUM_BUFS);
    localparam int unsigned IDX_W = ptr_w(MESH_WIDTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    if (MESH_WIDTH < 2) begin : g_bad_mesh_width
        $error("wl_stage_mb: MESH_WIDTH must be >= 2");
    end
    if (NUM_BUFS < 2) begin : g_bad_num_bufs
        $error("wl_stage_mb: NUM_BUFS must be >= 2");
    end

    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    idx_t beat_q, beat_d;
    cnt_t full_q, full_d;
    logic flag_q, flag_d;
    logic accept, last_beat, release_ok, beat_tr;

    `WL_TILE_T(MESH_WIDTH, DATA_WIDTH) tiles [NUM_BUFS];

    // Ready looks only at registered state (plus clear/reset), never at valid or release.
    assign w_ready_o    = !rst_i && !clear_i && (full_q < cnt_t'(NUM_BUFS));
    assign mesh_valid_o = (full_q != '0);
    assign full_cnt_o   = full_q;

    assign accept     = w_valid_i && w_ready_o;
    assign last_beat  = accept && (beat_q == idx_t'(MESH_WIDTH - 1));
    assign release_ok = mesh_release_i && mesh_valid_o;
    // Beat 0 uses the live transpose input; later beats use the latched flag.
    assign beat_tr    = (beat_q == '0) ? w_transpose_i : flag_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        full_d   = full_q;
        flag_d   = flag_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            beat_d   = '0;
            full_d   = '0;
            flag_d   = 1'b0;
        end else begin
            if (accept) begin
                if (beat_q == '0) begin
                    flag_d = w_transpose_i;
                end
                beat_d = last_beat ? '0 : beat_q + idx_t'(1);
            end
            if (last_beat) begin
                wr_ptr_d = (wr_ptr_q == ptr_t'(NUM_BUFS - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
            end
            if (release_ok) begin
                rd_ptr_d = (rd_ptr_q == ptr_t'(NUM_BUFS - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
            end
            if (last_beat && !release_ok) begin
                full_d = full_q + cnt_t'(1);
            end else if (!last_beat && release_ok) begin
                full_d = full_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            full_q   <= '0;
            flag_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            full_q   <= full_d;
            flag_q   <= flag_d;
        end
    end

    for (genvar b = 0; b < NUM_BUFS; b++) begin : g_bank
        wl_tile_bank #(
            .MESH_WIDTH (MESH_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_W      (IDX_W)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clr_i       (clear_i),
            .we_i        (accept && (wr_ptr_q == ptr_t'(b))),
            .idx_i       (beat_q),
            .transpose_i (beat_tr),
            .data_i      (w_data_i),
            .tile_o      (tiles[b])
        );
    end

    always_comb begin
        weight_o = '0;
        if (mesh_valid_o) begin
            weight_o = tiles[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_wl_stage_mb.sv
// Self-checking bench for wl_stage_mb: directed vector table, async-reset sequence,
// and randomized traffic against a queue-based tile model.
module tb_wl_stage_mb;

    localparam int MW = 4;
    localparam int DW = 32;
    localparam int NB = 2;

    typedef logic [MW-1:0][MW-1:0][DW-1:0] tile_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           w_valid;
    logic           w_ready;
    logic [MW*DW-1:0] w_data;
    logic           w_tr;
    logic           mesh_valid;
    logic           rel;
    tile_t          weight;
    logic [1:0]     full_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wl_stage_mb #(
        .MESH_WIDTH (MW),
        .DATA_WIDTH (DW),
        .NUM_BUFS   (NB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .w_valid_i      (w_valid),
        .w_ready_o      (w_ready),
        .w_data_i       (w_data),
        .w_transpose_i  (w_tr),
        .mesh_valid_o   (mesh_valid),
        .mesh_release_i (rel),
        .weight_o       (weight),
        .full_cnt_o     (full_cnt)
    );

    // Reference model: FIFO of complete tiles plus one partially assembled tile.
    tile_t mq[$];
    tile_t part;
    int    pbeat;
    bit    pflag;

    task automatic chk(input string name, input logic [MW*MW*DW-1:0] act,
                       input logic [MW*MW*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [MW*DW-1:0] pat_beat(input int p, input int k);
        logic [MW*DW-1:0] d;
        for (int j = 0; j < MW; j++) d[DW*j +: DW] = DW'(256 * p + 16 * k + j);
        return d;
    endfunction

    function automatic tile_t pat_tile(input int p, input bit tr);
        tile_t t;
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++)
                t[r][c] = tr ? DW'(256 * p + 16 * c + r) : DW'(256 * p + 16 * r + c);
        return t;
    endfunction

    task automatic model_reset();
        mq.delete();
        part  = '0;
        pbeat = 0;
        pflag = 1'b0;
    endtask

    task automatic model_check(input string tag);
        tile_t ew;
        ew = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, "_ready"}, w_ready, (!clear && mq.size() < NB));
        chk({tag, "_mvalid"}, mesh_valid, (mq.size() != 0));
        chk({tag, "_cnt"}, full_cnt, mq.size());
        chk({tag, "_weight"}, weight, ew);
    endtask

    task automatic model_step();
        bit acc;
        bit rl;
        if (clear) begin
            model_reset();
        end else begin
            acc = w_valid && (mq.size() < NB);
            rl  = rel && (mq.size() != 0);
            if (rl) void'(mq.pop_front());
            if (acc) begin
                if (pbeat == 0) pflag = w_tr;
                for (int j = 0; j < MW; j++) begin
                    if (pflag) part[j][pbeat] = w_data[DW*j +: DW];
                    else       part[pbeat][j] = w_data[DW*j +: DW];
                end
                pbeat++;
                if (pbeat == MW) begin
                    mq.push_back(part);
                    pbeat = 0;
                end
            end
        end
    endtask

    task automatic apply(input bit v, input logic [MW*DW-1:0] d, input bit tr,
                         input bit r, input bit c);
        @(negedge clk);
        w_valid = v;
        w_data  = d;
        w_tr    = tr;
        rel     = r;
        clear   = c;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        bit v; int k; int pat; bit tr; bit rl; bit cl;
        bit e_rdy; bit e_mv; int e_cnt; int w_pat; bit w_tr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit v, input int k, input int pat, input bit tr, input bit rl,
                       input bit cl, input bit e_rdy, input bit e_mv, input int e_cnt,
                       input int w_pat, input bit wt);
        vec_t e;
        e = '{v, k, pat, tr, rl, cl, e_rdy, e_mv, e_cnt, w_pat, wt};
        tbl.push_back(e);
    endtask

    initial begin
        tile_t ew;
        rst = 1'b1; clear = 1'b0; w_valid = 1'b0; w_data = '0; w_tr = 1'b0; rel = 1'b0;
        model_reset();
        #2;
        chk("reset_ready", w_ready, 1'b0);
        chk("reset_mvalid", mesh_valid, 1'b0);
        chk("reset_cnt", full_cnt, 2'd0);
        chk("reset_weight", weight, '0);
        @(negedge clk);
        rst = 1'b0;

        // Normal tile, then release.
        for (int k = 0; k < MW; k++) add(1, k, 0, 0, 0, 0, 1, 0, 0, -1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        // Transposed tile; transpose only asserted on beat 0.
        add(1, 0, 1, 1, 0, 0, 1, 0, 0, -1, 0);
        for (int k = 1; k < MW; k++) add(1, k, 1, 0, 0, 0, 1, 0, 0, -1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1);
        // Fill A and B, stall the third tile, release frees a slot one cycle later.
        for (int k = 0; k < MW; k++) add(1, k, 2, 0, 0, 0, 1, 0, 0, -1, 0);
        for (int k = 0; k < MW; k++) add(1, k, 3, 0, 0, 0, 1, 1, 1, 2, 0);
        add(1, 0, 4, 0, 0, 0, 0, 1, 2, 2, 0);
        add(1, 0, 4, 0, 1, 0, 0, 1, 2, 2, 0);
        for (int k = 0; k < MW; k++) add(1, k, 4, 0, 0, 0, 1, 1, 1, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 2, 3, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 4, 0);
        // Completion and release in the same cycle.
        for (int k = 0; k < MW; k++) add(1, k, 5, 0, 0, 0, 1, 0, 0, -1, 0);
        for (int k = 0; k < MW - 1; k++) add(1, k, 6, 0, 0, 0, 1, 1, 1, 5, 0);
        add(1, MW - 1, 6, 0, 1, 0, 1, 1, 1, 5, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 6, 0);
        // Clear discards a partial tile; the next tile starts at row 0.
        add(1, 0, 7, 0, 0, 0, 1, 0, 0, -1, 0);
        add(1, 1, 7, 0, 0, 0, 1, 0, 0, -1, 0);
        add(1, 2, 7, 0, 0, 1, 0, 0, 0, -1, 0);
        for (int k = 0; k < MW; k++) add(1, k, 8, 0, 0, 0, 1, 0, 0, -1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 8, 0);
        // Clear with a complete tile pending.
        for (int k = 0; k < MW; k++) add(1, k, 9, 0, 0, 0, 1, 0, 0, -1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 1, 9, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].v, pat_beat(tbl[i].pat, tbl[i].k), tbl[i].tr, tbl[i].rl, tbl[i].cl);
            model_check($sformatf("m%0d", i));
            ew = (tbl[i].w_pat < 0) ? '0 : pat_tile(tbl[i].w_pat, tbl[i].w_tr);
            chk($sformatf("v%0d_ready", i), w_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_mvalid", i), mesh_valid, tbl[i].e_mv);
            chk($sformatf("v%0d_cnt", i), full_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d_weight", i), weight, ew);
            step();
        end

        // Async reset mid-fill with a complete tile pending.
        for (int k = 0; k < MW; k++) begin
            apply(1, pat_beat(10, k), 0, 0, 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            apply(1, pat_beat(11, k), 0, 0, 0);
            step();
        end
        chk("pre_rst_cnt", full_cnt, 2'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_ready", w_ready, 1'b0);
        chk("async_mvalid", mesh_valid, 1'b0);
        chk("async_cnt", full_cnt, 2'd0);
        chk("async_weight", weight, '0);
        model_reset();
        w_valid = 1'b0;
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        rst = 1'b0;
        apply(0, '0, 0, 1, 0);
        model_check("rel_invalid");
        step();
        for (int k = 0; k < MW; k++) begin
            apply(1, pat_beat(12, k), 0, 0, 0);
            step();
        end
        apply(0, '0, 0, 0, 0);
        chk("post_rst_cnt", full_cnt, 2'd1);
        chk("post_rst_weight", weight, pat_tile(12, 0));
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            apply(($urandom % 4) != 0,
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 40) == 0);
            model_check($sformatf("r%0d", n));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wl_stage_mb.md
Name: wl_stage_mb

Overview:
- Multi-bank weight-load stage for the systolic mesh; successor to the fixed double-buffered weight loader.
- Accepts one MESH_WIDTH-element row per beat over a valid/ready handshake and assembles full MESH_WIDTH x MESH_WIDTH tiles into a ring of NUM_BUFS banks.
- Exposes the oldest complete tile to the mesh until the mesh releases it.
- Adds per-tile transpose mode, backpressure, and configurable bank depth.

Parameters:
MESH_WIDTH, 4, mesh rows/cols; >=2
DATA_WIDTH, 32, element width in bits
NUM_BUFS, 2, tile banks in the ring; >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous flush of all banks and pointers
w_valid_i  in  1  write beat valid
w_ready_o  out  1  write beat accepted when valid&ready
w_data_i  in  MESH_WIDTH*DATA_WIDTH  beat; element j at bits [DATA_WIDTH*j +: DATA_WIDTH]
w_transpose_i  in  1  tile transpose; sampled on the first beat of a tile
mesh_valid_o  out  1  read bank holds a complete tile
mesh_release_i  in  1  mesh finished with the current tile
weight_o  out  MESH_WIDTH x MESH_WIDTH x DATA_WIDTH  current tile, [row][col]
full_cnt_o  out  $clog2(NUM_BUFS+1)  number of complete, unreleased tiles

Behaviour:
- Reset (rst_i high, async):
  - wr_ptr=rd_ptr=0, beat_cnt=0, full_cnt=0, tile transpose flag=0, all bank data 0.
  - Outputs: w_ready_o=0 while rst_i is high, mesh_valid_o=0, weight_o=0, full_cnt_o=0.
- w_ready_o = !clear_i && (full_cnt < NUM_BUFS). Combinational from registered state only; never depends on w_valid_i.
- Accepted beat k (beat_cnt=k):
  - Normal: bank[wr_ptr][k][j] <= element j.
  - Transpose (flag latched at k=0): bank[wr_ptr][j][k] <= element j.
  - The latched flag applies to all MESH_WIDTH beats of the tile; w_transpose_i is ignored on beats 1..MESH_WIDTH-1.
- On the accepted beat with k=MESH_WIDTH-1:
  - beat_cnt wraps to 0.
  - wr_ptr advances, modulo NUM_BUFS.
  - full_cnt increments.
  - Tile is visible on the next cycle: last beat at cycle t gives mesh_valid_o=1 at t+1.
- mesh_valid_o = (full_cnt != 0).
- weight_o = bank[rd_ptr] when mesh_valid_o, else all zeros.
- Release: mesh_release_i && mesh_valid_o advances rd_ptr (modulo NUM_BUFS) and decrements full_cnt. Release while !mesh_valid_o is ignored.
- Bank contents are not cleared on release; the next fill overwrites every element.
- Tile completion and release in the same cycle: full_cnt unchanged, both pointers advance.
- Full ring (full_cnt=NUM_BUFS): w_ready_o=0. A release at cycle t raises w_ready_o at t+1, not t (no combinational ready path from mesh_release_i).
- Partial tile (beat_cnt>0): not visible to the mesh and not counted in full_cnt_o.
- clear_i (synchronous, highest priority over beats and release):
  - Pointers, beat_cnt, full_cnt and flag go to 0; all banks go to 0.
  - Any partial tile is discarded.
  - w_ready_o=0 during the clear cycle.
- Pointer wrap: wr_ptr/rd_ptr compare to NUM_BUFS-1 and wrap to 0, so non-power-of-two NUM_BUFS is legal.
- Elaboration errors: MESH_WIDTH<2 or NUM_BUFS<2.

Decomposition:
- Package wl_pkg: ptr_t and cnt_t width localparam helpers; the tile_t packed type [MESH_WIDTH][MESH_WIDTH][DATA_WIDTH] as a parametrised typedef macro.
- Sub-module wl_tile_bank (one per bank, generate loop):
  - Inputs: we, row/col index, transpose, beat data, clr.
  - Output: tile.
  - Performs the row/column scatter write.
- The top level holds the pointers, counters, handshake and read mux.

Test Plan (MESH_WIDTH=4, DATA_WIDTH=32, NUM_BUFS=2):
- Reset then 4 beats, beat k element j = 16*k+j, transpose=0 -> mesh_valid_o rises the cycle after beat 3; weight_o[r][c]=16*r+c; full_cnt_o=1.
- Same data with w_transpose_i=1 on beat 0 only -> weight_o[r][c]=16*c+r.
- Fill 2 tiles A then B, valid held high for a third tile -> w_ready_o=0 and full_cnt_o=2. Release -> weight_o shows B, w_ready_o=1 the following cycle, third tile lands in bank 0.
- Last beat of tile B and release of tile A in the same cycle -> full_cnt_o stays 1, weight_o=B next cycle, rd_ptr=1, wr_ptr=0.
- 2 beats of a tile then clear_i -> full_cnt_o=0, mesh_valid_o=0, weight_o=0. A following full 4-beat tile is stored with beat 0 in row 0, so no stale rows remain.
- Assert rst_i asynchronously mid-fill with one full tile pending -> all outputs 0 immediately; mesh_release_i pulsed while invalid -> no pointer change.
